// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI slave front end.
// Used by spi_slave, spi_tx_ser and spi_slave_if.
package spi_slave_pkg;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } spi_state_t;

  // Progress inside a word state: receiving, waiting on the RAM, serializing, done.
  typedef enum logic [1:0] {
    PH_RX,
    PH_WAIT,
    PH_SHIFT,
    PH_HOLD
  } phase_t;

endpackage

// File: rtl/spi_slave_if.sv
// SPI pins plus the RAM-side word/byte handshake of the SPI slave.
// slave modport is the spi_slave view; master is the SPI master + RAM view.
interface spi_slave_if;
  import spi_slave_pkg::*;

  logic                  SS_n;
  logic                  MOSI;
  logic                  MISO;
  logic [FRAME_BITS-1:0] rx_data;
  logic                  rx_valid;
  logic [DATA_BITS-1:0]  tx_data;
  logic                  tx_valid;
  logic                  err;

  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid, err
  );

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid, err
  );

endinterface

// File: rtl/spi_tx_ser.sv
// MSB-first byte serializer for MISO: load captures a byte and drives bit 7,
// then one bit per cycle; done pulses once MISO has returned to 0.
module spi_tx_ser
  import spi_slave_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 abort,
  output logic                 miso,
  output logic                 done
);

  logic [DATA_BITS-1:0] shreg;
  logic [2:0]           cnt;
  logic                 busy;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      miso  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        busy <= 1'b0;
        cnt  <= '0;
        miso <= 1'b0;
      end else if (load) begin
        shreg <= {data[DATA_BITS-2:0], 1'b0};
        miso  <= data[DATA_BITS-1];
        cnt   <= '0;
        busy  <= 1'b1;
      end else if (busy) begin
        if (cnt == 3'(DATA_BITS - 1)) begin
          miso <= 1'b0;
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          miso  <= shreg[DATA_BITS-1];
          shreg <= {shreg[DATA_BITS-2:0], 1'b0};
          cnt   <= cnt + 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/spi_slave.sv
// SPI slave front end for the single-port RAM: assembles 10-bit words from
// MOSI, strobes rx_valid, and serializes the RAM read byte on MISO.
// Optional read timeout with sticky err: define SPI_SLAVE_TIMEOUT_EN.
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int TX_TIMEOUT = 32
) (
  input  logic        clk,
  input  logic        rst,
  spi_slave_if.slave  bus
);

  spi_state_t            state;
  phase_t                phase;
  logic [3:0]            bit_cnt;
  logic [FRAME_BITS-1:0] rx_data;
  logic                  rx_valid;
  logic                  rd_addr_seen;
  logic                  err_q;
  logic                  ser_load;
  logic                  ser_done;
  logic                  miso;

`ifdef SPI_SLAVE_TIMEOUT_EN
  localparam int WAIT_W = (TX_TIMEOUT > 2) ? $clog2(TX_TIMEOUT) : 1;
  logic [WAIT_W-1:0] wait_cnt;
`else
  localparam int unused_tx_timeout = TX_TIMEOUT;
`endif

  // A reply is accepted only in the wait window of an active read-data frame.
  assign ser_load = (state == READ_DATA) && (phase == PH_WAIT) &&
                    bus.tx_valid && !bus.SS_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      phase        <= PH_RX;
      bit_cnt      <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rd_addr_seen <= 1'b0;
      err_q        <= 1'b0;
`ifdef SPI_SLAVE_TIMEOUT_EN
      wait_cnt     <= '0;
`endif
    end else begin
      rx_valid <= 1'b0;
      if (state != IDLE && bus.SS_n) begin
        state   <= IDLE;
        phase   <= PH_RX;
        bit_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (!bus.SS_n) begin
              state   <= CHK_CMD;
              phase   <= PH_RX;
              bit_cnt <= '0;
            end
          end
          CHK_CMD: begin
            if (!bus.MOSI)          state <= WRITE;
            else if (!rd_addr_seen) state <= READ_ADD;
            else                    state <= READ_DATA;
          end
          WRITE, READ_ADD, READ_DATA: begin
            case (phase)
              PH_RX: begin
                rx_data <= {rx_data[FRAME_BITS-2:0], bus.MOSI};
                if (bit_cnt == 4'(FRAME_BITS - 1)) begin
                  rx_valid <= 1'b1;
                  bit_cnt  <= '0;
                  if (state == READ_DATA) begin
                    rd_addr_seen <= 1'b0;
                    phase        <= PH_WAIT;
`ifdef SPI_SLAVE_TIMEOUT_EN
                    wait_cnt     <= '0;
`endif
                  end else begin
                    if (state == READ_ADD) rd_addr_seen <= 1'b1;
                    phase <= PH_HOLD;
                  end
                end else begin
                  bit_cnt <= bit_cnt + 4'd1;
                end
              end
              PH_WAIT: begin
                if (bus.tx_valid) begin
                  phase <= PH_SHIFT;
                end
`ifdef SPI_SLAVE_TIMEOUT_EN
                else if (wait_cnt == WAIT_W'(TX_TIMEOUT - 1)) begin
                  err_q        <= 1'b1;
                  rd_addr_seen <= 1'b0;
                  phase        <= PH_HOLD;
                end else begin
                  wait_cnt <= wait_cnt + 1'b1;
                end
`endif
              end
              PH_SHIFT: begin
                if (ser_done) phase <= PH_HOLD;
              end
              default: ;
            endcase
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  spi_tx_ser u_tx_ser (
    .clk   (clk),
    .rst   (rst),
    .load  (ser_load),
    .data  (bus.tx_data),
    .abort (bus.SS_n),
    .miso  (miso),
    .done  (ser_done)
  );

  assign bus.MISO     = miso;
  assign bus.rx_data  = rx_data;
  assign bus.rx_valid = rx_valid;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: directed cases plus randomized frames
// checked against a frame-level model of the SPI command protocol.
module tb_spi_slave;
  import spi_slave_pkg::*;

`ifdef SPI_SLAVE_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 32;
`endif

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  bit   model_seen = 1'b0;
  bit   model_err  = 1'b0;

  spi_slave_if bus ();

  spi_slave #(.TX_TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Shifts select bit + word; abort_bit >= 0 raises SS_n with that word bit.
  task automatic rx_word(input bit sel, input logic [9:0] word, input int abort_bit,
                         input bit spurious, output bit early);
    early = 1'b0;
    bus.SS_n = 1'b0;
    step();
    bus.MOSI = sel;
    step();
    for (int i = 0; i < FRAME_BITS; i++) begin
      bus.MOSI     = word[9-i];
      bus.tx_valid = spurious && (i == 4);
      bus.tx_data  = 8'($urandom);
      if (i == abort_bit) begin
        bus.SS_n = 1'b1;
        step();
        bus.tx_valid = 1'b0;
        return;
      end
      step();
      if (i < FRAME_BITS - 1) early |= bus.rx_valid;
    end
    bus.tx_valid = 1'b0;
  endtask

  // Full frame with model update; read-data frames get a RAM reply after
  // 1 + tx_delay cycles and the MISO byte is compared bit by bit.
  task automatic do_frame(input bit sel, input logic [9:0] word, input logic [7:0] tx_byte,
                          input int tx_delay, input bit spurious);
    bit early;
    bit rd_data;
    bit exp_bits[$];
    rd_data = sel && model_seen;
    rx_word(sel, word, -1, spurious, early);
    check("rx_valid_early", 32'(early), 0);
    check("rx_valid", 32'(bus.rx_valid), 1);
    check("rx_data", 32'(bus.rx_data), 32'(word));
    if (sel) model_seen = !model_seen;
    check("rd_addr_seen", 32'(dut.rd_addr_seen), 32'(model_seen));
    step();
    check("rx_valid_pulse", 32'(bus.rx_valid), 0);
    if (rd_data) begin
      for (int b = 7; b >= 0; b--) exp_bits.push_back(tx_byte[b]);
      for (int d = 0; d < tx_delay; d++) step();
      bus.tx_valid = 1'b1;
      bus.tx_data  = tx_byte;
      step();
      bus.tx_valid = 1'b0;
      while (exp_bits.size() > 0) begin
        check("miso_bit", 32'(bus.MISO), 32'(exp_bits.pop_front()));
        step();
      end
      check("miso_tail", 32'(bus.MISO), 0);
      step();
      check("miso_hold", 32'(bus.MISO), 0);
    end else begin
      check("miso_idle", 32'(bus.MISO), 0);
    end
    check("err", 32'(bus.err), 32'(model_err));
    bus.SS_n = 1'b1;
    step();
    check("state_idle", 32'(dut.state), 32'(IDLE));
  endtask

  initial begin
    bit early;
    logic [9:0] w;
    bit s;

    rst = 1'b1;
    bus.SS_n = 1'b1;
    bus.MOSI = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data = 8'h00;
    step();
    step();
    check("rst_miso", 32'(bus.MISO), 0);
    check("rst_rx_data", 32'(bus.rx_data), 0);
    check("rst_rx_valid", 32'(bus.rx_valid), 0);
    check("rst_err", 32'(bus.err), 0);
    check("rst_state", 32'(dut.state), 32'(IDLE));
    check("rst_seen", 32'(dut.rd_addr_seen), 0);
    rst = 1'b0;
    step();

    // Write address, write data, read address, read data.
    do_frame(1'b0, 10'h00F, 8'h00, 0, 1'b0);
    do_frame(1'b0, 10'h1AA, 8'h00, 0, 1'b1);
    do_frame(1'b1, 10'h20F, 8'h00, 0, 1'b0);
    do_frame(1'b1, 10'h3A5, 8'hC3, 0, 1'b0);

    // Abort after 5 word bits, then a full frame.
    rx_word(1'b0, 10'h155, 5, 1'b0, early);
    check("abort5_rx_valid", 32'(bus.rx_valid), 0);
    check("abort5_state", 32'(dut.state), 32'(IDLE));
    step();
    check("abort5_rx_valid_late", 32'(bus.rx_valid), 0);
    do_frame(1'b0, 10'h0E7, 8'h00, 0, 1'b0);

    // SS_n rises on the 10th bit edge of a read-address frame.
    rx_word(1'b1, {OP_RD_ADDR, 8'h44}, 9, 1'b0, early);
    check("abort10_rx_valid", 32'(bus.rx_valid), 0);
    check("abort10_state", 32'(dut.state), 32'(IDLE));
    check("abort10_seen", 32'(dut.rd_addr_seen), 32'(model_seen));
    step();
    check("abort10_rx_valid_late", 32'(bus.rx_valid), 0);

    // SS_n rises mid-serialization.
    do_frame(1'b1, {OP_RD_ADDR, 8'h12}, 8'h00, 0, 1'b0);
    rx_word(1'b1, {OP_RD_DATA, 8'h00}, -1, 1'b0, early);
    model_seen = 1'b0;
    step();
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'hA5;
    step();
    bus.tx_valid = 1'b0;
    check("ss_mid_b7", 32'(bus.MISO), 1);
    step();
    check("ss_mid_b6", 32'(bus.MISO), 0);
    step();
    check("ss_mid_b5", 32'(bus.MISO), 1);
    bus.SS_n = 1'b1;
    step();
    check("ss_mid_miso", 32'(bus.MISO), 0);
    check("ss_mid_state", 32'(dut.state), 32'(IDLE));

    // Reset during serialization of 8'hFF.
    do_frame(1'b1, {OP_RD_ADDR, 8'h33}, 8'h00, 0, 1'b0);
    rx_word(1'b1, {OP_RD_DATA, 8'h00}, -1, 1'b0, early);
    step();
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'hFF;
    step();
    bus.tx_valid = 1'b0;
    check("rst_ser_b7", 32'(bus.MISO), 1);
    step();
    step();
    rst = 1'b1;
    step();
    check("rst_mid_miso", 32'(bus.MISO), 0);
    check("rst_mid_rx_valid", 32'(bus.rx_valid), 0);
    check("rst_mid_state", 32'(dut.state), 32'(IDLE));
    check("rst_mid_seen", 32'(dut.rd_addr_seen), 0);
    rst = 1'b0;
    bus.SS_n = 1'b1;
    model_seen = 1'b0;
    step();

    // Randomized frames with matching opcodes and variable RAM latency.
    for (int n = 0; n < 24; n++) begin
      s = 1'($urandom);
      if (!s)              w = {($urandom_range(0, 1) != 0) ? OP_WR_DATA : OP_WR_ADDR, 8'($urandom)};
      else if (model_seen) w = {OP_RD_DATA, 8'($urandom)};
      else                 w = {OP_RD_ADDR, 8'($urandom)};
      do_frame(s, w, 8'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
    end

`ifdef SPI_SLAVE_TIMEOUT_EN
    // Read-data frame with the RAM reply withheld.
    if (!model_seen) do_frame(1'b1, {OP_RD_ADDR, 8'h5A}, 8'h00, 0, 1'b0);
    rx_word(1'b1, {OP_RD_DATA, 8'h00}, -1, 1'b0, early);
    model_seen = 1'b0;
    for (int c = 1; c <= TMO; c++) begin
      step();
      check("tmo_err_rise", 32'(bus.err), (c == TMO) ? 32'd1 : 32'd0);
    end
    check("tmo_seen", 32'(dut.rd_addr_seen), 0);
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'hFF;
    step();
    bus.tx_valid = 1'b0;
    step();
    check("tmo_miso", 32'(bus.MISO), 0);
    check("tmo_state", 32'(dut.state), 32'(READ_DATA));
    bus.SS_n = 1'b1;
    step();
    model_err = 1'b1;
    do_frame(1'b0, 10'h0C4, 8'h00, 0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_err = 1'b0;
    check("tmo_err_clear", 32'(bus.err), 0);
`endif

    check("final_err", 32'(bus.err), 32'(model_err));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
